mips_trace_monitor: RTL
=======================

Name: mips_trace_monitor

Overview:
Parametrised retirement monitor for the MIPS single-cycle core. It replaces ad-hoc simulation printing with synthesizable hardware.
- Classifies each retired instruction from opcode/funct.
- Keeps saturating per-class counters, a cycle counter and a drop counter.
- Buffers {pc, class, wd} trace records in a FIFO drained via valid/ready.
- Sits beside the core and taps pc, opcode, funct and register-file write data.

Parameters:
PC_W, 32, width of pc and rd_pc
DATA_W, 32, width of wd and rd_wd
DEPTH, 16, trace FIFO entries; power of two, >= 2
CNT_W, 32, width of every counter

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, asynchronous, active-high; every register clears immediately on assertion
en  in  1  an instruction retires this cycle
clr  in  1  synchronous clear of counters, FIFO and ovf
pc  in  PC_W  PC of the retiring instruction
opcode  in  6  instruction[31:26]
funct  in  6  instruction[5:0]
wd  in  DATA_W  register-file write data of the retiring instruction
rd_valid  out  1  FIFO head valid
rd_ready  in  1  consumer accepts the head
rd_pc  out  PC_W  head PC
rd_class  out  4  head class code
rd_wd  out  DATA_W  head write data
cnt_sel  in  4  counter select
cnt_val  out  CNT_W  selected counter value (combinational read)
cycle_cnt  out  CNT_W  cycles since reset or clr
drop_cnt  out  CNT_W  records dropped because the FIFO was full
ovf  out  1  sticky: at least one drop since reset or clr

Behaviour:
- Class codes:
  - opcode 0: funct 32 -> ADD=0; 34 -> SUB=1; 36 -> AND=2; 37 -> OR=3.
  - opcode 35 -> LW=4; 43 -> SW=5; 4 -> BEQ=6; 2 -> J=7.
  - Anything else, including opcode 0 with any other funct -> OTHER=8.
- Reset values: all counters 0, FIFO empty, rd_valid=0, rd_pc/rd_class/rd_wd=0, ovf=0, cnt_val=0.
- cycle_cnt: +1 every clock edge while rst=0 and clr=0; wraps modulo 2^CNT_W.
- Per-class counters (9): +1 on each edge with en=1; saturate at 2^CNT_W-1.
- cnt_val: cnt_sel 0..8 selects that class counter; 9 selects the total retired count (also saturating); 10..15 return 0.
- FIFO push:
  - On en=1, record {pc, class, wd} is written.
  - Latency: rd_valid rises on the edge after the push.
  - Output is first-word-fall-through: rd_* always shows the head while rd_valid=1.
- Pop: occurs on an edge where rd_valid=1 and rd_ready=1.
  - rd_ready while empty has no effect.
- Full FIFO with a push:
  - Without a simultaneous pop: record dropped, drop_cnt +1 (saturating), ovf set.
  - With a simultaneous pop: push accepted, no drop, occupancy stays DEPTH.
- Empty FIFO with push + rd_ready: push only; the new entry is not popped in the same cycle.
- Pointers: log2(DEPTH)+1 bits wide; wrap naturally.
  - full = pointers differ only in the MSB.
  - empty = pointers equal.
- clr=1:
  - Next edge zeroes all counters, empties the FIFO and clears ovf.
  - clr has priority: any push and pop that cycle are ignored, and nothing is counted.
- rst asserted mid-operation: immediate clear to reset values; no record survives.

Optional Feature:
TRACE_FILTER_EN
- Defined:
  - Adds input port filter_mask, width 9. The FIFO push requires en=1 and filter_mask[class]=1.
  - Class counters still count every retirement.
  - Filtered-out records are neither pushed nor counted as drops.
- Undefined: no filter_mask port; every retirement is pushed.

Test Plan:
1. Reset, then en=1 for 4 cycles with (opcode,funct) = (0,32), (35,x), (43,x), (2,x), pc=0x0,0x4,0x8,0xC -> counters ADD=LW=SW=J=1; cnt_sel=9 gives 4; FIFO pops classes 0,4,5,7 with pc 0x0,0x4,0x8,0xC in order.
2. DEPTH=16, rd_ready=0, 20 ADD retirements -> 16 entries held, drop_cnt=4, ovf=1; draining yields the first 16 pcs.
3. FIFO full, en=1 and rd_ready=1 on the same edge -> no drop, occupancy 16, head advances, drop_cnt unchanged.
4. opcode 0, funct 39 and opcode 8 -> OTHER counter +2, rd_class=8 for both entries.
5. clr asserted with en=1 and 5 entries queued -> next cycle all counters 0, rd_valid=0, ovf=0, no record from the clr cycle. Separately, rst pulsed mid-stream -> immediate zero outputs.
6. TRACE_FILTER_EN with filter_mask=9'b000110000, stream ADD, LW, SW, BEQ -> FIFO holds only LW and SW; class counters = 1 each.

Source files
------------

// File: rtl/mips_trace_monitor_if.sv
// Retirement tap and trace read channel of the MIPS trace monitor.
// The core side drives the retirement fields and rd_ready; the monitor drives the read head.
interface mips_trace_monitor_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  logic              en;
  logic [PC_W-1:0]   pc;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [DATA_W-1:0] wd;
  logic              rd_valid;
  logic              rd_ready;
  logic [PC_W-1:0]   rd_pc;
  logic [3:0]        rd_class;
  logic [DATA_W-1:0] rd_wd;

  modport master (
    output en, pc, opcode, funct, wd, rd_ready,
    input  rd_valid, rd_pc, rd_class, rd_wd
  );

  modport slave (
    input  en, pc, opcode, funct, wd, rd_ready,
    output rd_valid, rd_pc, rd_class, rd_wd
  );
endinterface

// File: rtl/mips_trace_monitor.sv
// Retirement monitor: classifies retired instructions, keeps per-class/cycle/drop counters
// and buffers {pc, class, wd} records in a FWFT FIFO. Optional macro TRACE_FILTER_EN adds filter_mask.
module mips_trace_monitor #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  mips_trace_monitor_if.slave tr,
  input  logic [3:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_val,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] drop_cnt,
`ifdef TRACE_FILTER_EN
  input  logic [8:0]       filter_mask,
`endif
  output logic             ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wp, rp;
  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [3:0]         mem_class [DEPTH];
  logic [DATA_W-1:0]  mem_wd    [DEPTH];
  logic [CNT_W-1:0]   cls_cnt   [9];
  logic [CNT_W-1:0]   total_cnt;
  logic [3:0]         cls;
  logic               empty, full, keep, push_req, pop, push_ok, drop;

  always_comb begin
    cls = 4'd8;
    if (tr.opcode == 6'd0) begin
      case (tr.funct)
        6'd32:   cls = 4'd0;
        6'd34:   cls = 4'd1;
        6'd36:   cls = 4'd2;
        6'd37:   cls = 4'd3;
        default: cls = 4'd8;
      endcase
    end else begin
      case (tr.opcode)
        6'd35:   cls = 4'd4;
        6'd43:   cls = 4'd5;
        6'd4:    cls = 4'd6;
        6'd2:    cls = 4'd7;
        default: cls = 4'd8;
      endcase
    end
  end

`ifdef TRACE_FILTER_EN
  assign keep = filter_mask[cls];
`else
  assign keep = 1'b1;
`endif

  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign push_req = tr.en & keep;
  assign pop      = !empty & tr.rd_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok  = push_req & (!full | pop);
  assign drop     = push_req & full & !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      cycle_cnt <= '0;
      drop_cnt  <= '0;
      total_cnt <= '0;
      ovf       <= 1'b0;
      for (int i = 0; i < 9; i++) cls_cnt[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_class[i] <= '0;
        mem_wd[i]    <= '0;
      end
    end else if (clr) begin
      wp        <= '0;
      rp        <= '0;
      cycle_cnt <= '0;
      drop_cnt  <= '0;
      total_cnt <= '0;
      ovf       <= 1'b0;
      for (int i = 0; i < 9; i++) cls_cnt[i] <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (tr.en) begin
        if (cls_cnt[cls] != '1) cls_cnt[cls] <= cls_cnt[cls] + 1'b1;
        if (total_cnt != '1)    total_cnt    <= total_cnt + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (push_ok) begin
        mem_pc[wp[AW-1:0]]    <= tr.pc;
        mem_class[wp[AW-1:0]] <= cls;
        mem_wd[wp[AW-1:0]]    <= tr.wd;
        wp                    <= wp + 1'b1;
      end
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    tr.rd_valid = !empty;
    tr.rd_pc    = '0;
    tr.rd_class = '0;
    tr.rd_wd    = '0;
    if (!empty) begin
      tr.rd_pc    = mem_pc[rp[AW-1:0]];
      tr.rd_class = mem_class[rp[AW-1:0]];
      tr.rd_wd    = mem_wd[rp[AW-1:0]];
    end
  end

  always_comb begin
    cnt_val = '0;
    if (cnt_sel < 4'd9)       cnt_val = cls_cnt[cnt_sel];
    else if (cnt_sel == 4'd9) cnt_val = total_cnt;
  end
endmodule
